exe_completion_arbiter: RTL

//  Shares the single EX->MEM result slot among the execution units (ALU, MUL, DIV, FP,

---
 rtl/exe_completion_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/exe_completion_arbiter.sv
// Completion arbiter for the EX->MEM result slot: fixed priority by unit code with aging,
// one registered output stage that honours MEM backpressure and pipeline flush.
module exe_completion_arbiter #(
    parameter int unsigned N_UNITS  = 10,
    parameter int unsigned DATA_W   = 151,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_UNITS-1:0]          req_valid_i,
    input  logic [N_UNITS*DATA_W-1:0]   req_data_i,
    output logic [N_UNITS-1:0]          req_ready_o,
    output logic                        out_valid_o,
    output logic [DATA_W-1:0]           out_data_o,
    output logic [3:0]                  out_unit_o,
    input  logic                        out_ready_i,
    input  logic                        flush_i,
    output logic                        busy_o
);

    localparam int unsigned         WAIT_W       = $clog2(MAX_WAIT + 1);
    localparam int unsigned         UNIT_W       = 4;
    localparam int unsigned         TIED_SLOT    = 7;
    localparam logic [UNIT_W-1:0]   DEFAULT_UNIT = 4'b0111;
    localparam logic [WAIT_W-1:0]   WAIT_SAT     = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0]  wait_cnt [N_UNITS];
    logic [N_UNITS-1:0] elig;
    logic [N_UNITS-1:0] aged;
    logic [N_UNITS-1:0] cand;
    logic [N_UNITS-1:0] grant;
    logic [UNIT_W-1:0]  grant_unit;
    logic [DATA_W-1:0]  grant_data;
    logic               accept;
    logic               grant_en;

    // Eligible requesters (tied-off slot excluded) and those that have waited long enough
    always_comb begin
        elig = '0;
        aged = '0;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            elig[i] = req_valid_i[i] && (i != TIED_SLOT);
            aged[i] = elig[i] && (wait_cnt[i] == WAIT_SAT);
        end
    end

    assign accept   = ~out_valid_o | out_ready_i;
    // reset_n gates the grant so no ready escapes while the output stage is held in reset
    assign grant_en = accept & ~flush_i & reset_n;
    assign cand     = (|aged) ? aged : elig;

    // Lowest index wins within the candidate set; payload muxed alongside
    always_comb begin
        grant      = '0;
        grant_unit = DEFAULT_UNIT;
        grant_data = '0;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            if ((grant == '0) && cand[i]) begin
                grant[i]   = 1'b1;
                grant_unit = UNIT_W'(i);
                grant_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
        if (!grant_en) begin
            grant = '0;
        end
    end

    assign req_ready_o = grant;
    assign busy_o      = (|req_valid_i) | out_valid_o;

    // Output stage: flush discards, accept loads or empties, otherwise hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_unit_o  <= DEFAULT_UNIT;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            if (|grant) begin
                out_valid_o <= 1'b1;
                out_data_o  <= grant_data;
                out_unit_o  <= grant_unit;
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

    // Per-slot wait counters, saturating so an aged slot stays aged until served
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_UNITS; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_UNITS; i++) begin
                if (flush_i || grant[i] || !elig[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != WAIT_SAT) begin
                    wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                end
            end
        end
    end

endmodule
